// File: rtl/seq_div_8by4_pkg.sv
// Shared types and constants for the sequential restoring divider.
// The state enum is kept here so checkers and the bench can decode state_q.
package div_pkg;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Quotient reported for a zero divisor at the default width.
    localparam logic [DW_DEF-1:0] DZ_QUOT = {DW_DEF{1'b1}};

endpackage

// File: rtl/seq_div_8by4_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference when it does not borrow.
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW:0]   prem_i,
    input  logic          bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW:0]   prem_o,
    output logic          qbit_o
);

    logic [VW+1:0] shifted;
    logic [VW+1:0] diff;
    logic [VW+1:0] next_val;
    logic          unused_msb;

    // One extra bit of headroom keeps the compare exact even before the
    // incoming remainder is known to be below the divisor.
    always_comb begin
        shifted    = {prem_i, bit_i};
        diff       = shifted - {2'b00, divisor_i};
        qbit_o     = (shifted >= {2'b00, divisor_i});
        next_val   = qbit_o ? diff : shifted;
        prem_o     = next_val[VW:0];
        unused_msb = next_val[VW+1];
    end

endmodule

// File: rtl/seq_div_8by4.sv
// Sequential restoring divider, one quotient bit per clock.
// Handshake: start is sampled only while ready=1 (IDLE); done pulses for one
// cycle in DONE and quotient/remainder/div_by_zero hold until the next result.
module seq_div_8by4
    import div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW) + 1;

    state_e        state_q,     state_d;
    logic [CW-1:0] count_q,     count_d;
    logic [VW:0]   prem_q,      prem_d;
    logic [DW-1:0] shift_q,     shift_d;
    logic [VW-1:0] divisor_q,   divisor_d;
    logic [DW-1:0] quotient_q,  quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          dbz_q,       dbz_d;

    logic [VW:0]   step_prem;
    logic          step_qbit;

    div_step #(.VW(VW)) u_step (
        .prem_i    (prem_q),
        .bit_i     (shift_q[DW-1]),
        .divisor_i (divisor_q),
        .prem_o    (step_prem),
        .qbit_o    (step_qbit)
    );

    // shift_q starts as the dividend and fills with quotient bits from the LSB.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        prem_d      = prem_q;
        shift_d     = shift_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = {DW{1'b1}};
                        remainder_d = '0;
                        dbz_d       = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        divisor_d = divisor;
                        shift_d   = dividend;
                        prem_d    = '0;
                        count_d   = '0;
                        state_d   = ST_DIVIDE;
                    end
                end
            end
            ST_DIVIDE: begin
                prem_d  = step_prem;
                shift_d = {shift_q[DW-2:0], step_qbit};
                count_d = count_q + CW'(1);
                if (count_q == CW'(DW - 1)) begin
                    quotient_d  = {shift_q[DW-2:0], step_qbit};
                    remainder_d = step_prem[VW-1:0];
                    dbz_d       = 1'b0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            prem_q      <= '0;
            shift_q     <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            prem_q      <= prem_d;
            shift_q     <= shift_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign ready       = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_DIVIDE);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_div_8by4.md
Name: seq_div_8by4

Overview:
- Sequential restoring divider: unsigned 8-bit dividend by unsigned 4-bit divisor, producing an 8-bit quotient and a 4-bit remainder.
- Inverse companion to the team's 4x4 array multiplier. It lets a product be decomposed back into its factor and residue.
- Sits beside the multiplier in the project arithmetic area with a simple start/ready/done handshake.
- Retires one quotient bit per clock.

Parameters:
- DW, 8, dividend and quotient width.
- VW, 4, divisor and remainder width; must satisfy VW <= DW.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- dividend  input  DW  unsigned dividend; captured on accepted start.
- divisor  input  VW  unsigned divisor; captured on accepted start.
- ready  output  1  high in IDLE only.
- busy  output  1  high in DIVIDE only.
- done  output  1  one-cycle pulse; result valid this cycle and held afterward.
- quotient  output  DW  result quotient.
- remainder  output  VW  result remainder.
- div_by_zero  output  1  set with done when captured divisor==0; held with the result.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state=IDLE, ready=1, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Internal count, partial remainder and shift register are all 0.
- States: IDLE, DIVIDE, DONE.
- IDLE:
  - start=1 at edge k with divisor!=0: latch operands, clear the partial remainder, count=0, go to DIVIDE.
  - start=1 with divisor==0: go straight to DONE with quotient={DW{1}}, remainder=0, div_by_zero=1. done is visible in the cycle after edge k.
- DIVIDE, each edge:
  - Shift the partial remainder (VW+1 bits) left, bringing in the dividend MSB.
  - Trial-subtract the divisor. If no borrow, keep the difference and shift quotient bit 1 in; otherwise restore and shift 0 in.
  - count increments. After DW edges (edges k+1..k+DW) go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - quotient and remainder registered and stable; div_by_zero=0 for a normal divide.
  - Next edge returns to IDLE unconditionally.
  - Outputs hold their values until the next accepted start.
- Latency: done is visible in the cycle after edge k+DW (DW+1 edges from start sample). Throughput is one divide per DW+2 cycles.
- start while busy or in DONE: ignored, no queuing. Operand inputs may change freely after capture.
- Held start: a new divide is accepted on the first IDLE cycle after DONE.
- Reset mid-operation: rst=1 on any edge forces reset values at that edge and discards the in-flight divide. rst has priority over start.
- Width rules:
  - The partial remainder is VW+1 bits so the trial subtract never overflows.
  - The final remainder is its low VW bits, always < divisor.
  - quotient*divisor + remainder == dividend for divisor!=0.
- All state updates use nonblocking assignments in a single sequential block. Next-state and datapath logic are fully assigned in every branch, with no inferred latches.

Decomposition:
- Package div_pkg: the state enum (IDLE, DIVIDE, DONE as a 2-bit logic enum), default widths DW_DEF=8 and VW_DEF=4, and the divide-by-zero quotient constant DZ_QUOT={DW{1}}.
- Sub-module div_step (combinational, parameterised by VW), one restoring step:
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: next partial remainder and quotient bit.
  - The top module holds the FSM, counter and registers.

Test Plan:
- 200/7: start at edge k -> done at cycle after k+8, quotient=28, remainder=4, div_by_zero=0; busy high for exactly 8 cycles.
- 255/15 then 5/9 back-to-back (start held high) -> 17 r0, then 0 r5; second accepted only in the IDLE cycle after DONE.
- 13/0 -> done in cycle after the start edge, quotient=8'hFF, remainder=0, div_by_zero=1; the next 13/1 gives 13 r0 with div_by_zero cleared.
- 100/3 with start pulsed again and operands changed to 50/5 during DIVIDE -> result still 33 r1; the extra start is ignored.
- rst=1 at DIVIDE count 4 of 144/12 -> next cycle ready=1, done=0, quotient=0, remainder=0; a fresh 144/12 gives 12 r0.
- Random sweep of all 256x15 nonzero pairs -> quotient*divisor+remainder==dividend and remainder<divisor each time.
